lut_func_unit: RTL and testbench

- Programmable successor to our fixed sum-of-minterms function blocks.
- Holds F independently loadable truth tables of K inputs each, and evaluates the function chosen per request through a registered valid/ready pipeline.
- A built-in sweep engine enumerates all 2^K input combinations of one table and counts its minterms; the QM minimisation flow uses this count to cross-check reduced covers.

---
 rtl/lut_func_unit_if.sv | 34 +++
 rtl/lut_func_unit.sv | 123 ++++++++++++
 tb/tb_lut_func_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_func_unit_if.sv
// Request/response and configuration bundle for lut_func_unit.
// master = requester/configurer, slave = the LUT unit.
interface lut_func_unit_if #(
    parameter int K    = 4,
    parameter int SELW = 1
);
    logic              cfg_we;
    logic [SELW-1:0]   cfg_fn;
    logic [2**K-1:0]   cfg_tt;
    logic              in_valid;
    logic              in_ready;
    logic [K-1:0]      in_x;
    logic [SELW-1:0]   in_sel;
    logic              out_valid;
    logic              out_ready;
    logic              out_o;
    logic              sweep_start;
    logic [SELW-1:0]   sweep_sel;
    logic              sweep_busy;
    logic              sweep_done;
    logic [K:0]        sweep_count;

    modport master (
        output cfg_we, cfg_fn, cfg_tt, in_valid, in_x, in_sel, out_ready,
               sweep_start, sweep_sel,
        input  in_ready, out_valid, out_o, sweep_busy, sweep_done, sweep_count
    );

    modport slave (
        input  cfg_we, cfg_fn, cfg_tt, in_valid, in_x, in_sel, out_ready,
               sweep_start, sweep_sel,
        output in_ready, out_valid, out_o, sweep_busy, sweep_done, sweep_count
    );
endinterface

// File: rtl/lut_func_unit.sv
// F programmable K-input truth tables with a 1-cycle valid/ready evaluator
// and a sweep engine that counts the minterms of one table.
module lut_func_unit #(
    parameter int K    = 4,
    parameter int F    = 2,
    parameter int SELW = (F > 1) ? $clog2(F) : 1
) (
    input  logic clk,
    input  logic rst_n,
    lut_func_unit_if.slave bus
);
    localparam int DEPTH = 2**K;
    localparam int NSEL  = 2**SELW;
    localparam logic [SELW:0] F_LIM = (SELW+1)'(F);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} sweep_state_t;

    sweep_state_t state_q, state_d;

    // Rows at index >= F are never written, so they read back as all-zero.
    logic [DEPTH-1:0] tables [NSEL];

    logic [SELW-1:0] sel_q;
    logic [K-1:0]    idx_q;
    logic [K:0]      acc_q;
    logic [K:0]      count_q;
    logic            scan_bit;

    logic            sweep_busy;
    logic            sweep_done;
    logic            in_ready;
    logic            accept;
    logic            out_valid_q;
    logic            out_o_q;
    logic [DEPTH-1:0] eval_row;

    // Table storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSEL; i++) tables[i] <= '0;
        end else if (bus.cfg_we && !sweep_busy && ({1'b0, bus.cfg_fn} < F_LIM)) begin
            tables[bus.cfg_fn] <= bus.cfg_tt;
        end
    end

    // Evaluation pipeline
    always_comb begin
        in_ready = !sweep_busy && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        eval_row = tables[bus.in_sel];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_o_q     <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_o_q     <= eval_row[bus.in_x];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sweep FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Sweep FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sweep_start) state_d = SCAN;
            SCAN:    if (idx_q == '1)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sweep FSM: outputs
    always_comb begin
        sweep_busy = (state_q == SCAN);
        sweep_done = (state_q == DONE);
    end

    // Sweep datapath; the final bit is folded into count_q on the SCAN->DONE
    // edge so the count is already valid during the done pulse.
    assign scan_bit = tables[sel_q][idx_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.sweep_start) begin
                        sel_q <= bus.sweep_sel;
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= acc_q + {{K{1'b0}}, scan_bit};
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == '1) count_q <= acc_q + {{K{1'b0}}, scan_bit};
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_o       = out_o_q;
    assign bus.sweep_busy  = sweep_busy;
    assign bus.sweep_done  = sweep_done;
    assign bus.sweep_count = count_q;
endmodule

// File: tb/tb_lut_func_unit.sv
// Scoreboard bench for lut_func_unit (K=4, F=3): directed evaluations,
// backpressure, sweeps, write/read collision and reset mid-sweep.
module tb_lut_func_unit;
    localparam int K     = 4;
    localparam int F     = 3;
    localparam int SELW  = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lut_func_unit_if #(.K(K), .SELW(SELW)) bus ();

    lut_func_unit #(.K(K), .F(F), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int stall_cycles = 0;
    logic [DEPTH-1:0] model [4];
    logic exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic model_bit(input logic [SELW-1:0] s, input logic [K-1:0] x);
        logic [DEPTH-1:0] row;
        row = model[s];
        return row[x];
    endfunction

    // Monitor: retire presented results, then record newly accepted requests
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got out_o=%0b expected no result", bus.out_o);
                end else begin
                    check("eval_out_o", {31'd0, bus.out_o}, {31'd0, exp_q.pop_front()});
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model_bit(bus.in_sel, bus.in_x));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end at posedge+1
    task automatic send(input logic [SELW-1:0] s, input logic [K-1:0] x);
        bit acc;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_x     = x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1;
                break;
            end
            stall_cycles++;
        end
        if (!acc) check("send_accept", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic write_tbl(input logic [SELW-1:0] fn, input logic [DEPTH-1:0] tt);
        bus.cfg_we = 1'b1;
        bus.cfg_fn = fn;
        bus.cfg_tt = tt;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        model[fn]  = tt;
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sweep(input logic [SELW-1:0] s, input int exp_cnt, input bit poke);
        int done_at;
        int ready_in_scan;
        int busy_missing;
        logic [K:0] cnt;
        done_at = -1;
        ready_in_scan = 0;
        busy_missing = 0;
        cnt = '0;
        bus.sweep_start = 1'b1;
        bus.sweep_sel   = s;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.sweep_done && done_at < 0) begin
                done_at = n;
                cnt = bus.sweep_count;
            end
            if (n >= 1 && n <= 16) begin
                if (bus.in_ready)    ready_in_scan++;
                if (!bus.sweep_busy) busy_missing++;
            end
            @(posedge clk); #1;
            bus.sweep_start = 1'b0;
            if (poke) begin
                bus.cfg_we = (n == 8);
                bus.cfg_fn = s;
                bus.cfg_tt = '1;
            end
            if (done_at >= 0) break;
        end
        bus.cfg_we = 1'b0;
        check("sweep_done_latency", done_at, 17);
        check("sweep_count", {27'd0, cnt}, exp_cnt);
        check("sweep_in_ready_low", ready_in_scan, 0);
        check("sweep_busy_high", busy_missing, 0);
        @(negedge clk);
        check("sweep_done_single", {31'd0, bus.sweep_done}, 0);
        check("sweep_count_hold", {27'd0, bus.sweep_count}, exp_cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 4; i++) model[i] = '0;
        bus.cfg_we = 0; bus.cfg_fn = '0; bus.cfg_tt = '0;
        bus.in_valid = 0; bus.in_x = '0; bus.in_sel = '0;
        bus.out_ready = 1; bus.sweep_start = 0; bus.sweep_sel = '0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_o", {31'd0, bus.out_o}, 0);
        check("rst_sweep_busy", {31'd0, bus.sweep_busy}, 0);
        check("rst_sweep_done", {31'd0, bus.sweep_done}, 0);
        check("rst_sweep_count", {27'd0, bus.sweep_count}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;

        send(0, 3);
        send(0, 10);
        drain();

        write_tbl(0, 16'h9A6D);
        write_tbl(1, 16'hC1F8);
        stall_cycles = 0;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                send(SELW'(s), K'(x));
        check("stream_no_stall", stall_cycles, 0);
        @(negedge clk);
        check("latency_last_valid", {31'd0, bus.out_valid}, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_drained", {31'd0, bus.out_valid}, 0);
        @(posedge clk); #1;

        // Backpressure: first request x5 of fn0 (=1), then x0 of fn1 (=0) held off
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_sel = 0; bus.in_x = 5;
        @(negedge clk);
        check("bp_first_accept", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;
        bus.in_sel = 1; bus.in_x = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", {31'd0, bus.in_ready}, 0);
            check("bp_out_valid_hold", {31'd0, bus.out_valid}, 1);
            check("bp_out_o_hold", {31'd0, bus.out_o}, 1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
        drain();

        sweep(0, 9, 1);
        send(0, 1);
        send(0, 4);
        drain();

        sweep(3, 0, 0);
        write_tbl(2, 16'hFFFF);
        sweep(2, 16, 0);
        send(3, 5);
        send(2, 5);
        drain();

        // Collision: write fn1=0 while evaluating fn1[3]; old value 1 expected
        bus.cfg_we = 1; bus.cfg_fn = 1; bus.cfg_tt = 16'h0000;
        bus.in_valid = 1; bus.in_sel = 1; bus.in_x = 3;
        @(negedge clk);
        check("collision_accept", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;
        bus.cfg_we = 0; bus.in_valid = 0;
        model[1] = 16'h0000;
        send(1, 3);
        drain();

        // Reset 8 cycles into a sweep of fn0
        dones = 0;
        bus.sweep_start = 1; bus.sweep_sel = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.sweep_done) dones++;
            @(posedge clk); #1;
            bus.sweep_start = 0;
            if (n == 7) rst_n = 0;
            if (n == 9) rst_n = 1;
        end
        for (int i = 0; i < 4; i++) model[i] = '0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_no_done", dones, 0);
        check("midrst_count", {27'd0, bus.sweep_count}, 0);
        check("midrst_busy", {31'd0, bus.sweep_busy}, 0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;
        send(2, 5);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
